// File: rtl/wb_sram_arbiter.sv
// wb_sram_arbiter: two-master Wishbone arbiter in front of the 16-bit SRAM
// controller. A master owns the slave for a whole Wishbone cycle. Ownership
// alternates round-robin when both masters request. A watchdog ends a strobe
// that the slave never answers by returning an error to the owning master.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   m0_* / m1_*         Wishbone master ports (cyc/stb/we/adr/sel/dat in,
//                       dat/ack/err out)
//   s_*                 Wishbone slave port toward the SRAM controller
//   grant_o             one-hot current owner (bit0 = m0), 00 when idle
//   timeout_o           one-cycle pulse when the watchdog fires
module wb_sram_arbiter #(
  parameter int adr_width = 32,
  parameter int timeout   = 255,
  parameter int cnt_width = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m0_cyc_i,
  input  logic                 m0_stb_i,
  input  logic                 m0_we_i,
  input  logic [adr_width-1:0] m0_adr_i,
  input  logic [3:0]           m0_sel_i,
  input  logic [31:0]          m0_dat_i,
  output logic [31:0]          m0_dat_o,
  output logic                 m0_ack_o,
  output logic                 m0_err_o,
  input  logic                 m1_cyc_i,
  input  logic                 m1_stb_i,
  input  logic                 m1_we_i,
  input  logic [adr_width-1:0] m1_adr_i,
  input  logic [3:0]           m1_sel_i,
  input  logic [31:0]          m1_dat_i,
  output logic [31:0]          m1_dat_o,
  output logic                 m1_ack_o,
  output logic                 m1_err_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  output logic                 s_we_o,
  output logic [adr_width-1:0] s_adr_o,
  output logic [3:0]           s_sel_o,
  output logic [31:0]          s_dat_o,
  input  logic [31:0]          s_dat_i,
  input  logic                 s_ack_i,
  output logic [1:0]           grant_o,
  output logic                 timeout_o
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t               state, state_next;
  logic                 last, last_next;
  logic [cnt_width-1:0] cnt;
  logic                 granted, own_cyc, own_stb, pending, wd_fire;

  // Read data is broadcast; only the acked master samples it.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  always_comb begin
    granted = (state != IDLE);
    own_cyc = 1'b0;
    own_stb = 1'b0;
    if (state == GNT0) begin
      own_cyc = m0_cyc_i;
      own_stb = m0_stb_i;
    end else if (state == GNT1) begin
      own_cyc = m1_cyc_i;
      own_stb = m1_stb_i;
    end
    // An ack in the same cycle the count expires wins over the watchdog.
    pending = granted & own_stb & ~s_ack_i;
    wd_fire = (timeout != 0) && (cnt == cnt_width'(timeout)) && pending;
  end

  // Slave-side and master-side outputs
  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_adr_o   = '0;
    s_sel_o   = '0;
    s_dat_o   = '0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    grant_o   = {state == GNT1, state == GNT0};
    timeout_o = wd_fire;
    if (state == GNT0) begin
      s_cyc_o  = m0_cyc_i;
      s_stb_o  = m0_stb_i & ~wd_fire;
      s_we_o   = m0_we_i;
      s_adr_o  = m0_adr_i;
      s_sel_o  = m0_sel_i;
      s_dat_o  = m0_dat_i;
      m0_ack_o = s_ack_i;
      m0_err_o = wd_fire;
    end else if (state == GNT1) begin
      s_cyc_o  = m1_cyc_i;
      s_stb_o  = m1_stb_i & ~wd_fire;
      s_we_o   = m1_we_i;
      s_adr_o  = m1_adr_i;
      s_sel_o  = m1_sel_i;
      s_dat_o  = m1_dat_i;
      m1_ack_o = s_ack_i;
      m1_err_o = wd_fire;
    end
  end

  // Next-state: the release cycle (owner's cyc low) doubles as the mandatory
  // s_cyc_o-low gap, so a waiting master can be handed the slave directly.
  always_comb begin
    state_next = state;
    last_next  = last;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_next = last ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_next = GNT0;
        else if (m1_cyc_i)        state_next = GNT1;
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          last_next  = 1'b0;
          state_next = m1_cyc_i ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          last_next  = 1'b1;
          state_next = m0_cyc_i ? GNT0 : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_next;
      last  <= last_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || (state_next != state) || s_ack_i || wd_fire) begin
      cnt <= '0;
    end else if (s_stb_o) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_sram_arbiter.sv
module tb_wb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:0] m0_adr_i, m0_dat_i;
  logic [3:0]  m0_sel_i;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m1_adr_i, m1_dat_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] s_dat_i;
  logic        s_ack_i;

  // DUT with a short watchdog
  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o, timeout_o;
  logic [3:0]  s_sel_o;
  logic [1:0]  grant_o;

  // DUT with the watchdog disabled, same stimulus
  logic [31:0] m0_dat_o_b, m1_dat_o_b, s_adr_o_b, s_dat_o_b;
  logic        m0_ack_o_b, m0_err_o_b, m1_ack_o_b, m1_err_o_b;
  logic        s_cyc_o_b, s_stb_o_b, s_we_o_b, timeout_o_b;
  logic [3:0]  s_sel_o_b;
  logic [1:0]  grant_o_b;

  int errors = 0;
  int checks = 0;

  localparam int TMO = 4;

  wb_sram_arbiter #(.adr_width(32), .timeout(TMO), .cnt_width(8)) dut (
    .clk(clk), .reset(reset),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
    .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
    .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  wb_sram_arbiter #(.adr_width(32), .timeout(0), .cnt_width(8)) dut_b (
    .clk(clk), .reset(reset),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
    .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o_b), .m0_ack_o(m0_ack_o_b),
    .m0_err_o(m0_err_o_b),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
    .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o_b), .m1_ack_o(m1_ack_o_b),
    .m1_err_o(m1_err_o_b),
    .s_cyc_o(s_cyc_o_b), .s_stb_o(s_stb_o_b), .s_we_o(s_we_o_b), .s_adr_o(s_adr_o_b),
    .s_sel_o(s_sel_o_b), .s_dat_o(s_dat_o_b), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o_b), .timeout_o(timeout_o_b)
  );

  always #5 clk = ~clk;

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_sel_i = '0; m0_dat_i = '0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_sel_i = '0; m1_dat_i = '0;
    s_dat_i = '0; s_ack_i = 0;
  endtask

  task automatic set_master(input int idx, input bit cyc, input bit stb);
    if (idx == 0) begin m0_cyc_i = cyc; m0_stb_i = stb; end
    else          begin m1_cyc_i = cyc; m1_stb_i = stb; end
  endtask

  task automatic do_reset();
    reset = 1;
    clear_inputs();
    clk_step();
    clk_step();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1; s_ack_i = 1;
    clk_step();
    @(negedge clk);
    checks++;
    if ({s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, grant_o, timeout_o} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got cyc=%b stb=%b ack=%b%b err=%b%b grant=%b tmo=%b, want all 0",
               s_cyc_o, s_stb_o, m1_ack_o, m0_ack_o, m1_err_o, m0_err_o, grant_o, timeout_o);
    end
    do_reset();
  endtask

  task automatic test_single_read();
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 32'h4000_0010; m0_sel_i = 4'hF;
    @(negedge clk);
    checks++;
    if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL read_latency: s_cyc_o=%b want 0", s_cyc_o); end
    clk_step();
    @(negedge clk);
    checks++;
    if ({s_cyc_o, s_stb_o, grant_o} !== 4'b1101 || s_adr_o !== 32'h4000_0010) begin
      errors++;
      $display("FAIL read_grant: cyc=%b stb=%b grant=%b adr=%h want 1 1 01 40000010", s_cyc_o, s_stb_o, grant_o, s_adr_o);
    end
    clk_step();
    s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'hDEAD_BEEF || m1_ack_o !== 1'b0 || m0_err_o !== 1'b0) begin
      errors++;
      $display("FAIL read_ack: m0_ack=%b dat=%h m1_ack=%b err=%b want 1 deadbeef 0 0", m0_ack_o, m0_dat_o, m1_ack_o, m0_err_o);
    end
    clk_step();
    clear_inputs();
    clk_step();
    @(negedge clk);
    checks++;
    if (grant_o !== 2'b00) begin errors++; $display("FAIL read_release: grant=%b want 00", grant_o); end
  endtask

  task automatic test_contention();
    logic [1:0] want;
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h100;
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h200;
    clk_step();
    for (int i = 0; i < 4; i++) begin
      int owner = i % 2;
      want = (owner == 0) ? 2'b01 : 2'b10;
      s_ack_i = 1; s_dat_i = $urandom;
      @(negedge clk);
      checks++;
      if (grant_o !== want || (owner == 0 ? m0_ack_o : m1_ack_o) !== 1'b1 ||
          (owner == 0 ? m1_ack_o : m0_ack_o) !== 1'b0 ||
          s_adr_o !== (owner == 0 ? 32'h100 : 32'h200)) begin
        errors++;
        $display("FAIL contention_round%0d: grant=%b ack=%b%b adr=%h want grant %b", i, grant_o, m1_ack_o, m0_ack_o, s_adr_o, want);
      end
      clk_step();
      s_ack_i = 0;
      set_master(owner, 0, 0);
      @(negedge clk);
      checks++;
      if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL contention_gap%0d: s_cyc_o=%b want 0", i, s_cyc_o); end
      clk_step();
      set_master(owner, 1, 1);
    end
    clear_inputs();
    clk_step();
    clk_step();
  endtask

  task automatic test_grant_hold();
    int acks = 0;
    do_reset();
    m1_cyc_i = 1; m1_adr_i = 32'h300;
    clk_step();
    m0_cyc_i = 1; m0_stb_i = 1;
    for (int k = 0; k < 3; k++) begin
      m1_stb_i = 1; s_ack_i = 0;
      clk_step();
      s_ack_i = 1;
      @(negedge clk);
      if (m1_ack_o === 1'b1 && m0_ack_o === 1'b0 && grant_o === 2'b10) acks++;
      clk_step();
      s_ack_i = 0; m1_stb_i = 0;
      clk_step();
    end
    checks++;
    if (acks !== 3) begin errors++; $display("FAIL hold_acks: got %0d acks to m1 want 3", acks); end
    @(negedge clk);
    checks++;
    if (grant_o !== 2'b10) begin errors++; $display("FAIL hold_keep: grant=%b want 10", grant_o); end
    m1_cyc_i = 0;
    clk_step();
    @(negedge clk);
    checks++;
    if (grant_o !== 2'b01) begin errors++; $display("FAIL hold_handover: grant=%b want 01", grant_o); end
    clear_inputs();
    clk_step();
    clk_step();
  endtask

  task automatic test_watchdog();
    int early = 0;
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1;
    clk_step();
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (m0_err_o !== 1'b0 || timeout_o !== 1'b0 || s_stb_o !== 1'b1) early++;
      clk_step();
    end
    checks++;
    if (early !== 0) begin errors++; $display("FAIL wd_early: %0d bad cycles before expiry want 0", early); end
    @(negedge clk);
    checks++;
    if ({m0_err_o, timeout_o, s_stb_o, m0_ack_o, m1_err_o} !== 5'b11000) begin
      errors++;
      $display("FAIL wd_fire: err=%b tmo=%b stb=%b ack=%b m1_err=%b want 1 1 0 0 0", m0_err_o, timeout_o, s_stb_o, m0_ack_o, m1_err_o);
    end
    checks++;
    if (m0_err_o_b !== 1'b0 || s_stb_o_b !== 1'b1) begin
      errors++;
      $display("FAIL wd_disabled_fire: err_b=%b stb_b=%b want 0 1", m0_err_o_b, s_stb_o_b);
    end
    clk_step();
    @(negedge clk);
    checks++;
    if (m0_err_o !== 1'b0 || timeout_o !== 1'b0 || s_stb_o !== 1'b1) begin
      errors++;
      $display("FAIL wd_one_cycle: err=%b tmo=%b stb=%b want 0 0 1", m0_err_o, timeout_o, s_stb_o);
    end
    clear_inputs();
    clk_step();
    clk_step();
  endtask

  task automatic test_ack_race();
    int bad = 0;
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1;
    clk_step();
    repeat (TMO) clk_step();
    s_ack_i = 1;
    @(negedge clk);
    checks++;
    if ({m0_ack_o, m0_err_o, timeout_o} !== 3'b100) begin
      errors++;
      $display("FAIL race_ack_wins: ack=%b err=%b tmo=%b want 1 0 0", m0_ack_o, m0_err_o, timeout_o);
    end
    clk_step();
    s_ack_i = 0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (m0_err_o !== 1'b0) bad++;
      clk_step();
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL race_count_cleared: %0d early errors want 0", bad); end
    clear_inputs();
    clk_step();
    clk_step();
  endtask

  task automatic test_disabled();
    int fires = 0;
    int drops = 0;
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1;
    clk_step();
    repeat (1000) begin
      @(negedge clk);
      if (m0_err_o_b || timeout_o_b) fires++;
      if (s_stb_o_b !== 1'b1) drops++;
      clk_step();
    end
    checks++;
    if (fires !== 0) begin errors++; $display("FAIL disabled_errs: %0d errors want 0", fires); end
    checks++;
    if (drops !== 0) begin errors++; $display("FAIL disabled_stb: %0d stb drops want 0", drops); end
    clear_inputs();
    clk_step();
    clk_step();
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_dat_i = 32'h1234_5678;
    clk_step();
    @(negedge clk);
    checks++;
    if (s_we_o !== 1'b1 || grant_o !== 2'b10 || s_dat_o !== 32'h1234_5678) begin
      errors++;
      $display("FAIL midwr_grant: we=%b grant=%b dat=%h want 1 10 12345678", s_we_o, grant_o, s_dat_o);
    end
    clk_step();
    reset = 1;
    clk_step();
    reset = 0;
    @(negedge clk);
    checks++;
    if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || grant_o !== 2'b00 || m1_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL midwr_reset: cyc=%b stb=%b grant=%b ack=%b want 0 0 00 0", s_cyc_o, s_stb_o, grant_o, m1_ack_o);
    end
    clear_inputs();
    clk_step();
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    clk_step();
    @(negedge clk);
    checks++;
    if (grant_o !== 2'b01) begin errors++; $display("FAIL midwr_regrant: grant=%b want 01", grant_o); end
    clear_inputs();
    clk_step();
    clk_step();
  endtask

  // Reference model: owner is -1 (none), 0 or 1; wait counts unanswered
  // strobe cycles for the short-watchdog DUT.
  task automatic test_random();
    int owner = -1, last = 1, waitc = 0, owner_n;
    int rem[2] = '{0, 0};
    bit cyc[2], stb[2], fire, e_cyc, e_stb;
    logic [31:0] e_adr, e_dat;
    logic [1:0]  e_grant, e_ack, e_err;
    do_reset();
    cyc = '{0, 0};
    for (int n = 0; n < 600; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (rem[m] == 0) begin
          cyc[m] = !cyc[m];
          rem[m] = cyc[m] ? $urandom_range(1, 10) : $urandom_range(0, 3);
        end else rem[m]--;
        stb[m] = cyc[m] && ($urandom_range(0, 3) != 0);
      end
      m0_cyc_i = cyc[0]; m0_stb_i = stb[0]; m0_we_i = $urandom; m0_adr_i = $urandom;
      m0_sel_i = $urandom; m0_dat_i = $urandom;
      m1_cyc_i = cyc[1]; m1_stb_i = stb[1]; m1_we_i = $urandom; m1_adr_i = $urandom;
      m1_sel_i = $urandom; m1_dat_i = $urandom;
      s_ack_i = ($urandom_range(0, 9) < 4); s_dat_i = $urandom;

      fire = (owner >= 0) && stb[owner] && !s_ack_i && (waitc == TMO);
      e_cyc = 0; e_stb = 0; e_adr = '0; e_dat = '0; e_grant = '0; e_ack = '0; e_err = '0;
      if (owner >= 0) begin
        e_cyc = cyc[owner];
        e_stb = stb[owner] && !fire;
        e_adr = (owner == 0) ? m0_adr_i : m1_adr_i;
        e_dat = (owner == 0) ? m0_dat_i : m1_dat_i;
        e_grant[owner] = 1'b1;
        e_ack[owner] = s_ack_i;
        e_err[owner] = fire;
      end
      @(negedge clk);
      checks++;
      if ({s_cyc_o, s_stb_o, grant_o, m1_ack_o, m0_ack_o, m1_err_o, m0_err_o, timeout_o} !==
          {e_cyc, e_stb, e_grant, e_ack, e_err, fire}) begin
        errors++;
        $display("FAIL rand_ctrl@%0d: cyc,stb,grant,ack,err,tmo=%b%b_%b_%b%b_%b%b_%b want %b%b_%b_%b_%b_%b",
                 n, s_cyc_o, s_stb_o, grant_o, m1_ack_o, m0_ack_o, m1_err_o, m0_err_o, timeout_o,
                 e_cyc, e_stb, e_grant, e_ack, e_err, fire);
      end
      checks++;
      if (s_adr_o !== e_adr || s_dat_o !== e_dat || m0_dat_o !== s_dat_i || m1_dat_o !== s_dat_i) begin
        errors++;
        $display("FAIL rand_data@%0d: adr=%h dat=%h want %h %h", n, s_adr_o, s_dat_o, e_adr, e_dat);
      end
      checks++;
      if ({m1_ack_o_b, m0_ack_o_b, m1_err_o_b, m0_err_o_b, timeout_o_b, grant_o_b} !== {e_ack, 3'b000, e_grant}) begin
        errors++;
        $display("FAIL rand_nowd@%0d: ack_b=%b%b err_b=%b%b tmo_b=%b grant_b=%b want ack %b grant %b",
                 n, m1_ack_o_b, m0_ack_o_b, m1_err_o_b, m0_err_o_b, timeout_o_b, grant_o_b, e_ack, e_grant);
      end

      owner_n = owner;
      if (owner < 0) begin
        if (cyc[0] && cyc[1]) owner_n = 1 - last;
        else if (cyc[0])      owner_n = 0;
        else if (cyc[1])      owner_n = 1;
      end else if (!cyc[owner]) begin
        last = owner;
        owner_n = cyc[1 - owner] ? 1 - owner : -1;
      end
      if (owner_n != owner || s_ack_i || fire) waitc = 0;
      else if (e_stb) waitc++;
      owner = owner_n;
      clk_step();
    end
    clear_inputs();
    clk_step();
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    clk_step();
    test_reset();
    test_single_read();
    test_contention();
    test_grant_hold();
    test_watchdog();
    test_ack_race();
    test_disabled();
    test_reset_mid_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
